// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle for bcd_countdown_timer.
// The master side drives the controls; the slave side is the timer.
interface bcd_countdown_timer_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  Load;
  logic [4*DIGITS-1:0]   LoadValue;
  logic                  Start;
  logic                  Stop;
  logic                  Tick;
  logic [4*DIGITS-1:0]   Digits;
  logic                  Running;
  logic                  Done;
  logic                  Expired;

  modport master (
    output Load, LoadValue, Start, Stop, Tick,
    input  Digits, Running, Done, Expired
  );

  modport slave (
    input  Load, LoadValue, Start, Stop, Tick,
    output Digits, Running, Done, Expired
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load, start/stop and expiry pulse.
// Control priority on each edge: Load > Stop > Start > Tick.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS = 4
) (
  input logic              Clk,
  input logic              Rst,
  bcd_countdown_timer_if.slave bus
);
  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t         state;
  logic [W-1:0]   count;
  logic [W-1:0]   dec;
  logic [W-1:0]   clamped;
  logic           running_q;
  logic           done_q;
  logic           expired_q;
  logic           borrow;
  logic           is_zero;
  logic           is_one;

  // Full borrow chain resolves combinationally in one cycle.
  always_comb begin
    dec    = '0;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
        end else begin
          dec[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end else begin
        dec[4*i +: 4] = count[4*i +: 4];
      end
    end
  end

  always_comb begin
    clamped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (bus.LoadValue[4*i +: 4] > 4'd9) ? 4'd9 : bus.LoadValue[4*i +: 4];
    end
  end

  assign is_zero = (count == '0);
  assign is_one  = (count == W'(1));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      count     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.Load) begin
        count     <= clamped;
        state     <= IDLE;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!bus.Stop && bus.Start) begin
              if (is_zero) begin
                state     <= DONE;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end else begin
                state     <= RUN;
                running_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bus.Stop) begin
              state     <= PAUSED;
              running_q <= 1'b0;
            end else if (bus.Tick) begin
              count <= dec;
              if (is_one) begin
                state     <= DONE;
                running_q <= 1'b0;
                done_q    <= 1'b1;
                expired_q <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (!bus.Stop && bus.Start) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          DONE: begin
            count <= '0;
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Digits  = count;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;
  assign bus.Expired = expired_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with DIGITS = 4.
module tb_bcd_countdown_timer;
  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  bcd_countdown_timer_if #(.DIGITS(4)) bus ();

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Apply one set of controls across a single rising edge, then release them.
  task automatic cycle(input logic ld, input logic [15:0] lv, input logic st,
                       input logic sp, input logic tk);
    bus.Load      = ld;
    bus.LoadValue = lv;
    bus.Start     = st;
    bus.Stop      = sp;
    bus.Tick      = tk;
    @(posedge Clk);
    #1;
    bus.Load  = 1'b0;
    bus.Start = 1'b0;
    bus.Stop  = 1'b0;
    bus.Tick  = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [15:0] d, input logic r,
                            input logic dn, input logic ex);
    check({tag, ".digits"},  32'(bus.Digits),  32'(d));
    check({tag, ".running"}, 32'(bus.Running), 32'(r));
    check({tag, ".done"},    32'(bus.Done),    32'(dn));
    check({tag, ".expired"}, 32'(bus.Expired), 32'(ex));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.Load = 1'b0; bus.LoadValue = '0; bus.Start = 1'b0; bus.Stop = 1'b0; bus.Tick = 1'b0;
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    Rst = 1'b0;

    // Borrow chain
    cycle(1, 16'h0102, 0, 0, 0);
    check_outs("t1.load", 16'h0102, 1'b0, 1'b0, 1'b0);
    cycle(0, 16'h0, 1, 0, 0);
    check_outs("t1.start", 16'h0102, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 101; i++) begin
      cycle(0, 16'h0, 0, 0, 1);
      check("t1.tick.digits", 32'(bus.Digits), 32'(to_bcd(102 - i)));
      check("t1.tick.done", 32'(bus.Done), 32'd0);
    end
    cycle(0, 16'h0, 0, 0, 1);
    check_outs("t1.terminal", 16'h0000, 1'b0, 1'b1, 1'b1);
    cycle(0, 16'h0, 0, 0, 0);
    check_outs("t1.after", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Clamp and long borrow
    cycle(1, 16'h1A0F, 0, 0, 0);
    check_outs("t2.clamp", 16'h1909, 1'b0, 1'b0, 1'b0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 0, 0, 1);
    check("t2.tick", 32'(bus.Digits), 32'h1908);
    cycle(1, 16'h1000, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 0, 0, 1);
    check_outs("t2.long", 16'h0999, 1'b1, 1'b0, 1'b0);

    // Pause and resume
    cycle(1, 16'h0005, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 0, 0, 1);
    cycle(0, 16'h0, 0, 0, 1);
    check("t3.two", 32'(bus.Digits), 32'h0003);
    cycle(0, 16'h0, 0, 1, 1);
    check_outs("t3.stop", 16'h0003, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle(0, 16'h0, 0, 0, 1);
    check_outs("t3.paused", 16'h0003, 1'b0, 1'b0, 1'b0);
    cycle(0, 16'h0, 1, 0, 1);
    check_outs("t3.resume", 16'h0003, 1'b1, 1'b0, 1'b0);
    cycle(0, 16'h0, 0, 0, 1);
    check_outs("t3.r1", 16'h0002, 1'b1, 1'b0, 1'b0);
    cycle(0, 16'h0, 0, 0, 1);
    check_outs("t3.r2", 16'h0001, 1'b1, 1'b0, 1'b0);
    cycle(0, 16'h0, 0, 0, 1);
    check_outs("t3.r3", 16'h0000, 1'b0, 1'b1, 1'b1);
    cycle(0, 16'h0, 0, 0, 0);
    check_outs("t3.after", 16'h0000, 1'b0, 1'b0, 1'b1);

    // Priority and zero start
    cycle(1, 16'h0000, 0, 0, 0);
    check_outs("t4.load0", 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(0, 16'h0, 1, 0, 0);
    check_outs("t4.zstart", 16'h0000, 1'b0, 1'b1, 1'b1);
    cycle(0, 16'h0, 0, 0, 0);
    check_outs("t4.zafter", 16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(1, 16'h0010, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(1, 16'h0042, 0, 0, 1);
    check_outs("t4.ldtick", 16'h0042, 1'b0, 1'b0, 1'b0);
    cycle(0, 16'h0, 0, 0, 1);
    check_outs("t4.idletick", 16'h0042, 1'b0, 1'b0, 1'b0);

    // DONE is sticky
    cycle(1, 16'h0001, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    cycle(0, 16'h0, 0, 0, 1);
    check_outs("t5.enter", 16'h0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 16'h0, 1, 0, 1);
      check_outs("t5.sticky", 16'h0000, 1'b0, 1'b0, 1'b1);
    end

    // Async reset mid-count
    cycle(1, 16'h0500, 0, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    repeat (10) cycle(0, 16'h0, 0, 0, 1);
    check_outs("t6.count", 16'h0490, 1'b1, 1'b0, 1'b0);
    #2;
    Rst = 1'b1;
    #1;
    check_outs("t6.async", 16'h0000, 1'b0, 1'b0, 1'b0);
    #1;
    Rst = 1'b0;
    cycle(0, 16'h0, 1, 0, 0);
    check_outs("t6.zstart", 16'h0000, 1'b0, 1'b1, 1'b1);
    cycle(0, 16'h0, 0, 0, 0);
    check_outs("t6.after", 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter with load, start/stop control and an expiry pulse. It is the counting-down counterpart of the single-digit mod-10 up-counter. Digits borrow from one another in decimal (0 wraps to 9 and borrows from the next digit). It sits beside the up-counters in the timing datapath: it takes a 1-cycle `Tick` strobe from a prescaler and drives the digit display and expiry logic.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1..8.
- `Clk` input 1: single clock, rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `Load` input 1: load `LoadValue` into the count; highest-priority control.
- `LoadValue` input 4*DIGITS: BCD preset; nibble i is digit i, nibble 0 is the least significant.
- `Start` input 1: begin or resume counting.
- `Stop` input 1: pause counting.
- `Tick` input 1: count-enable strobe; one decrement per cycle in which it is high.
- `Digits` output 4*DIGITS: current BCD count, registered.
- `Running` output 1: high while in state RUN.
- `Done` output 1: single-cycle pulse when the count reaches zero.
- `Expired` output 1: high while in state DONE.

## Operation
- Reset state:
  - State = IDLE.
  - `Digits` = 0, `Running` = 0, `Done` = 0, `Expired` = 0.
  - Applies immediately on `Rst` rising, independent of `Clk`.
- States:
  - IDLE: count loaded, not counting.
  - RUN: counting.
  - PAUSED: counting stopped by `Stop`.
  - DONE: count has reached zero.
- Control priority per edge: `Load` > `Stop` > `Start` > `Tick`.
- `Load`, in any state:
  - `Digits` <= `LoadValue`, with every nibble greater than 9 clamped to 9.
  - State <= IDLE; `Expired` <= 0.
  - Any simultaneous `Start`, `Stop` or `Tick` is ignored.
- IDLE:
  - `Start` with count != 0 -> RUN.
  - `Start` with count == 0 -> DONE and `Done` pulses.
  - `Tick` is ignored.
- RUN:
  - `Stop` -> PAUSED; a `Tick` in the same cycle is ignored.
  - `Tick` without `Stop`: decrement the count by 1 in BCD.
    - Digit 0 decrements.
    - A digit at 0 becomes 9 and propagates a borrow to the next digit.
    - A digit above 0 decrements by one, and the borrow stops there.
  - `Tick` with count == 1 (BCD) -> count becomes 0, state <= DONE, `Done` <= 1.
  - `Start` while in RUN has no effect.
- PAUSED:
  - `Start` -> RUN; a `Tick` in the same cycle is ignored.
  - `Tick` is ignored; the count holds.
- DONE:
  - `Digits` holds 0.
  - `Start`, `Stop` and `Tick` are ignored.
  - Only `Load` or `Rst` exits this state.
- `Done` is high only on the cycle immediately after entry into DONE; it is never high two cycles in a row.
- Count never wraps below zero. Underflow (0 to 99..9) is unreachable by construction.
- Every `Digits` nibble is always in 0..9.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `Load` at edge k: `LoadValue` appears on `Digits` after edge k; `Running` = 0 after edge k.
- `Start` at edge k from IDLE: `Running` = 1 after edge k. The first `Tick` that counts is the one sampled at edge k+1.
- `Tick` at edge k in RUN: the decremented value appears after edge k (1-cycle latency).
- Terminal tick at edge k, with count == 1:
  - After edge k: `Digits` = 0, `Done` = 1, `Expired` = 1, `Running` = 0.
  - After edge k+1: `Done` = 0.
- Back-to-back `Tick` on every cycle gives one decrement per cycle; the full borrow chain resolves within one cycle for all `DIGITS`.
- `Rst` asserted mid-count: outputs go to their reset values asynchronously. After release, the first edge with `Rst` low is a normal IDLE edge.

## Test plan
1. **Borrow chain.** `DIGITS`=4. Load 16'h0102, Start, then `Tick` every cycle.
   - Required `Digits`: 0102, 0101, 0100, 0099, 0098, ...
   - The `Done` pulse follows the 102nd tick; `Digits` = 0000 and `Expired` = 1.
2. **Clamp and long borrow.** Load 16'h1A0F.
   - `Digits` = 16'h1909.
   - Start, then one `Tick` -> 16'h1908.
   - Load 16'h1000, Start, one `Tick` -> 16'h0999.
3. **Pause and resume.** Load 0005, Start, 2 ticks -> 0003.
   - Stop together with a `Tick` -> state PAUSED, count 0003.
   - 3 further ticks -> still 0003.
   - Start, then 3 ticks -> 0000 with a single `Done` pulse.
4. **Priority and zero start.**
   - Load 0000, Start -> DONE and `Done` pulses once; `Running` never goes high.
   - In RUN, assert `Load` = 0042 together with `Tick` -> `Digits` = 0042, state IDLE.
5. **DONE is sticky.** In DONE, apply `Start` and `Tick` for 5 cycles.
   - `Digits` stays 0000, `Expired` stays 1, `Done` stays 0.
6. **Async reset mid-count.** Load 0500, Start, 10 ticks -> 0490.
   - Pulse `Rst` between clock edges -> `Digits` = 0000, `Running` = 0 immediately, without waiting for an edge.
   - After release, Start with no load -> DONE and `Done` pulses.
